// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Requester count is capped at MAX_REQ so one helper serves every build.
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_REQ        = 8;
    localparam int PTR_W          = 3;

    typedef enum logic {ARB, HOLD} arb_state_t;

    // One-hot pick of the first request at or above ptr, wrapping modulo n.
    // Scanning from the farthest offset down lets the nearest request win.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic [MAX_REQ-1:0] sh;
        int                 pos;
        pick = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                pos = (int'(ptr) + i) % n;
                sh  = req >> pos;
                if (sh[0]) begin
                    pick = MAX_REQ'(1) << pos;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin select: one-hot pick, its index, and a found flag.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  pick,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    logic [MAX_REQ-1:0] pick_all;

    assign pick_all = rr_pick(MAX_REQ'(req), PTR_W'(ptr), NUM_REQ);
    assign pick     = pick_all[NUM_REQ-1:0];
    assign any      = |pick_all;

    // Encode the one-hot pick into a requester index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_all[i]) begin
                idx = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grant is combinational; the winning word reaches the FIFO one cycle later.
// Optional macro FIFO_ARB_BURST_EN lets a winner keep the port for up to
// MAX_BURST consecutive words.
//
// state | meaning (FIFO_ARB_BURST_EN only)
// ARB   | plain round-robin from rr_ptr
// HOLD  | owner keeps priority while requesting, until MAX_BURST grants
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_afull,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [ID_WIDTH-1:0]           wr_id
);

    logic                  ok;
    logic                  any;
    logic                  grant;
    logic [NUM_REQ-1:0]    rr_pick_v;
    logic [ID_WIDTH-1:0]   rr_idx;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   win_idx;
    logic [DATA_WIDTH-1:0] win_data;

    // An in-flight write into an almost-full FIFO fills it, so block then too.
    assign ok = !fifo_full && !(fifo_wr_en && fifo_afull);

    rr_select #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr_select (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (rr_pick_v),
        .idx  (rr_idx),
        .any  (any)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t          state, state_nxt;
    logic [ID_WIDTH-1:0] owner, owner_nxt;
    logic [CNT_W-1:0]    burst_cnt, burst_cnt_nxt;
    logic                hold_own;

    // Burst state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grant selection and burst tracking; a stalled cycle in HOLD changes nothing.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        hold_own      = (state == HOLD) && req[owner];
        win_idx       = hold_own ? owner : rr_idx;
        gnt           = '0;
        if (!rst && ok) begin
            gnt = hold_own ? (NUM_REQ'(1) << owner) : rr_pick_v;
        end
        if ((state == HOLD) && !req[owner]) begin
            state_nxt = ARB;
        end
        if (|gnt) begin
            if (hold_own) begin
                burst_cnt_nxt = burst_cnt + CNT_W'(1);
                if (burst_cnt_nxt == CNT_W'(MAX_BURST)) begin
                    state_nxt = ARB;
                end
            end else begin
                owner_nxt     = rr_idx;
                burst_cnt_nxt = CNT_W'(1);
                state_nxt     = (MAX_BURST > 1) ? HOLD : ARB;
            end
        end
    end
`else
    assign win_idx = rr_idx;
    assign gnt     = (!rst && ok && any) ? rr_pick_v : '0;
`endif

    assign grant = |gnt;

    // Mux the winning requester's word.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_WIDTH'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Register the write and advance the pointer past each winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_en <= 1'b0;
            fifo_wdata <= '0;
            wr_id      <= '0;
            rr_ptr     <= '0;
        end else begin
            fifo_wr_en <= grant;
            if (grant) begin
                fifo_wdata <= win_data;
                wr_id      <= win_idx;
                rr_ptr     <= (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter with a 16-deep FIFO model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int IDW       = $clog2(NUM_REQ);
    localparam int DEPTH     = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    gnt;
    logic                  fifo_full;
    logic                  fifo_afull;
    logic                  fifo_wr_en;
    logic [DW-1:0]         fifo_wdata;
    logic [IDW-1:0]        wr_id;

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_afull (fifo_afull),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .wr_id      (wr_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            id;
    } wr_t;

    wr_t           sb[$];
    logic [DW-1:0] words[NUM_REQ][$];
    bit            act[NUM_REQ];
    bit            drop[NUM_REQ];
    bit            drain;
    bit            force_full;
    int            total = 0;
    int            bad   = 0;
    int            cnt   = 0;
    int            writes = 0;
    int            last_g = -1;
    int            m_ptr = 0;
    bit            m_hold = 0;
    int            m_owner = 0;
    int            m_bcnt = 0;
    bit            exp_wr = 0;
    bit            wr_known = 0;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int rr_ref(input logic [NUM_REQ-1:0] rv, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rv[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (words[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle: drive inputs, predict grant, check, update the models.
    task automatic step(input bit r);
        int                 g;
        bit                 ok;
        bit                 rd;
        logic [NUM_REQ-1:0] rv;
        @(negedge clk);
        rst      = r;
        rv       = '0;
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (words[i].size() > 0) begin
                req_data = req_data | ((NUM_REQ*DW)'(words[i][0]) << (i * DW));
                if (act[i] && !drop[i]) rv[i] = 1'b1;
            end
        end
        req        = rv;
        fifo_full  = force_full || (cnt >= DEPTH);
        fifo_afull = (cnt == DEPTH - 1);
        #1;
        if (wr_known) chk("wr_en", fifo_wr_en, exp_wr);
        chk("no_overflow", (fifo_wr_en && cnt >= DEPTH), 0);
        ok = !fifo_full && !(exp_wr && fifo_afull);
        g  = -1;
        if (!r && ok) begin
            g = rr_ref(rv, m_ptr);
`ifdef FIFO_ARB_BURST_EN
            if (m_hold && rv[m_owner]) g = m_owner;
`endif
        end
        chk("gnt", gnt, (g < 0) ? 0 : (1 << g));
        last_g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) last_g = k;
        end
        if (r) begin
            m_ptr = 0; m_hold = 0; m_owner = 0; m_bcnt = 0;
        end else begin
`ifdef FIFO_ARB_BURST_EN
            if (m_hold && !rv[m_owner]) m_hold = 0;
            if (g >= 0) begin
                if (m_hold) begin
                    m_bcnt++;
                    if (m_bcnt == MAX_BURST) m_hold = 0;
                end else begin
                    m_owner = g;
                    m_bcnt  = 1;
                    m_hold  = (MAX_BURST > 1);
                end
            end
`endif
            if (g >= 0) m_ptr = (g + 1) % NUM_REQ;
        end
        if (g >= 0) begin
            sb.push_back('{data: words[g][0], id: g});
            void'(words[g].pop_front());
        end
        rd = drain && (cnt > 0) && ($urandom_range(0, 1) == 1);
        if (fifo_wr_en) writes++;
        cnt    = cnt + (fifo_wr_en ? 1 : 0) - (rd ? 1 : 0);
        exp_wr = !r && (g >= 0);
        if (r) wr_known = 1;
    endtask

    task automatic settle();
        act        = '{default: 0};
        drop       = '{default: 0};
        force_full = 0;
        drain      = 1;
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0 && !exp_wr && all_empty() && cnt == 0) break;
            if (all_empty() == 0) act = '{default: 1};
            step(0);
        end
        chk("settled", sb.size() + cnt, 0);
        act = '{default: 0};
    endtask

    // Monitor: every presented write must match the oldest predicted grant.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            chk("gnt_onehot0", $onehot0(gnt), 1);
            if (fifo_wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_wr: data %0d id %0d with nothing granted", fifo_wdata, wr_id);
                end else begin
                    e = sb.pop_front();
                    chk("wdata", fifo_wdata, e.data);
                    chk("wr_id", wr_id, e.id);
                end
            end
        end
    end

    initial begin
        int ord[8];
        req        = '0;
        req_data   = '0;
        fifo_full  = 0;
        fifo_afull = 0;
        drain      = 1;
        force_full = 0;
        act        = '{default: 0};
        drop       = '{default: 0};

        repeat (3) step(1);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_wr_id", wr_id, 0);

        // single requester 2, three words
        words[2] = '{8'h11, 8'h22, 8'h33};
        act[2] = 1;
        for (int c = 0; c < 5; c++) begin
            step(0);
            chk("single_g", last_g, (c < 3) ? 2 : -1);
        end
        settle();

        // all four requesting straight after reset
        step(1);
`ifdef FIFO_ARB_BURST_EN
        ord = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int w = 0; w < 8; w++) words[i].push_back(DW'($urandom));
        end
        act = '{default: 1};
        for (int c = 0; c < 8; c++) begin
            step(0);
            chk("order", last_g, ord[c]);
        end
        settle();

        // fill a 16-deep FIFO with no reads
        drain  = 0;
        writes = 0;
        for (int w = 0; w < 20; w++) words[0].push_back(DW'($urandom));
        act[0] = 1;
        repeat (30) step(0);
        chk("fill_writes", writes, 16);
        chk("fill_cnt", cnt, 16);
        settle();

        // full forced for three cycles during a storm
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int w = 0; w < 6; w++) words[i].push_back(DW'($urandom));
        end
        act = '{default: 1};
        repeat (4) step(0);
        force_full = 1;
        repeat (3) begin
            step(0);
            chk("full_blk", last_g, -1);
        end
        force_full = 0;
        settle();

        // reset pulse right after a grant to requester 1
        words[1].push_back(8'h5a);
        act[1] = 1;
        for (int n = 0; n < 10; n++) begin
            step(0);
            if (last_g == 1) break;
        end
        chk("saw_g1", last_g, 1);
        words[0] = '{8'ha0, 8'ha1};
        words[2] = '{8'hc0, 8'hc1};
        act[0] = 1;
        act[2] = 1;
        step(1);
        step(0);
        chk("post_rst_g", last_g, 0);
        settle();

        // requester 3 withdraws while competing with 1
        words[1] = '{8'h01, 8'h02, 8'h03, 8'h04};
        words[3] = '{8'h33};
        act[1] = 1;
        act[3] = 1;
        step(0);
        drop[3] = 1;
        repeat (3) begin
            step(0);
            chk("drop3", gnt[3], 0);
        end
        drop[3] = 0;
        settle();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (words[i].size() < 3 && $urandom_range(0, 3) == 0) words[i].push_back(DW'($urandom));
                act[i]  = ($urandom_range(0, 3) != 0);
                drop[i] = ($urandom_range(0, 7) == 0);
            end
            force_full = ($urandom_range(0, 15) == 0);
            drain      = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 63) == 0);
        end
        settle();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
